// File: rtl/regfile_scoreboard_pkg.sv
// regfile_pkg: shared types, constants and helpers for the register file
package regfile_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;
    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
    typedef logic [DEF_DATA_W-1:0] word_t;
    localparam word_t BA_RESET_VAL = 16'h0040;
    function automatic int pend_max(input int pend_w);
        return (1 << pend_w) - 1;
    endfunction
endpackage

// File: rtl/regfile_scoreboard_pend_counter.sv
// pend_counter: saturating up/down count of outstanding writes to one register
module pend_counter
    import regfile_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_inc,
    input  logic              i_dec,
    output logic [PEND_W-1:0] o_cnt,
    output logic              o_at_max,
    output logic              o_nonzero
);
    logic [PEND_W-1:0] r_cnt;
    logic              w_inc;
    logic              w_dec;
    assign o_cnt     = r_cnt;
    assign o_at_max  = r_cnt == PEND_W'(pend_max(PEND_W));
    assign o_nonzero = r_cnt != '0;
    assign w_inc     = i_inc & !o_at_max;
    assign w_dec     = i_dec & o_nonzero;
    // count claims up and writebacks down; simultaneous events cancel, never wraps
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (w_inc != w_dec)
            r_cnt <= w_inc ? r_cnt + PEND_W'(1) : r_cnt - PEND_W'(1);
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with write-first bypass and pending-write scoreboard
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                NUM_RD   = 2,
    parameter int                PEND_W   = 2,
    parameter logic [DATA_W-1:0] BA_RESET = DATA_W'(BA_RESET_VAL)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        i_rd_valid,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_busy,
    output logic                     o_stall,
    input  logic                     i_iss_en,
    input  logic [ADDR_W-1:0]        i_iss_addr,
    output logic                     o_iss_ready,
    input  logic                     i_wr_en,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    output logic                     o_err
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0] r_regs [DEPTH];
    logic              r_err;
    logic [PEND_W-1:0] w_cnt [DEPTH];
    logic              w_at_max [DEPTH];
    logic              w_nz [DEPTH];
    for (genvar g = 0; g < DEPTH; g++) begin : g_cnt
        pend_counter #(.PEND_W(PEND_W)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .i_inc     (i_iss_en & (i_iss_addr == ADDR_W'(g))),
            .i_dec     (i_wr_en & (i_wr_addr == ADDR_W'(g))),
            .o_cnt     (w_cnt[g]),
            .o_at_max  (w_at_max[g]),
            .o_nonzero (w_nz[g])
        );
    end
    assign o_iss_ready = !w_at_max[i_iss_addr];
    assign o_stall     = |(i_rd_valid & o_rd_busy);
    assign o_err       = r_err;
    // read ports: write-first bypass, busy released when the last pending write lands now
    always_comb begin
        o_rd_data = '0;
        o_rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            o_rd_data[i*DATA_W +: DATA_W] = (i_wr_en & !rst & (i_wr_addr == i_rd_addr[i*ADDR_W +: ADDR_W]))
                ? i_wr_data : r_regs[i_rd_addr[i*ADDR_W +: ADDR_W]];
            o_rd_busy[i] = w_nz[i_rd_addr[i*ADDR_W +: ADDR_W]] &
                !((w_cnt[i_rd_addr[i*ADDR_W +: ADDR_W]] == PEND_W'(1)) & i_wr_en &
                  (i_wr_addr == i_rd_addr[i*ADDR_W +: ADDR_W]));
        end
    end
    // storage: BA resets to its base address, WB data always lands regardless of count
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++)
                r_regs[k] <= (k == 0) ? BA_RESET : '0;
        end else if (i_wr_en) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end
    // sticky flag for a writeback nobody claimed (e.g. stale WB after reset)
    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (i_wr_en & !w_nz[i_wr_addr])
            r_err <= 1'b1;
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and random checks against a register/scoreboard model
module tb_regfile_scoreboard;
    logic        clk = 0;
    logic        rst;
    logic [1:0]  rd_valid;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  rd_busy;
    logic        stall;
    logic        iss_en;
    logic [2:0]  iss_addr;
    logic        iss_ready;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        err;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] m_reg [8];
    int          m_cnt [8];
    bit          m_err;

    regfile_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .i_rd_valid (rd_valid),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .o_rd_busy  (rd_busy),
        .o_stall    (stall),
        .i_iss_en   (iss_en),
        .i_iss_addr (iss_addr),
        .o_iss_ready(iss_ready),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++) begin
            m_reg[r] = (r == 0) ? 16'h0040 : 16'h0000;
            m_cnt[r] = 0;
        end
        m_err = 0;
    endtask

    // compare all combinational outputs against the model, mid-cycle
    task automatic settle();
        logic [2:0]  a;
        logic [15:0] ed;
        bit          eb;
        bit          es;
        es = 0;
        #4;
        for (int i = 0; i < 2; i++) begin
            a  = rd_addr[i*3 +: 3];
            ed = (wr_en && !rst && wr_addr == a) ? wr_data : m_reg[a];
            eb = (m_cnt[a] > 0) && !(m_cnt[a] == 1 && wr_en && wr_addr == a);
            es = es | (rd_valid[i] & eb);
            chk($sformatf("rd_data%0d", i), 32'(rd_data[i*16 +: 16]), 32'(ed));
            chk($sformatf("rd_busy%0d", i), 32'(rd_busy[i]), 32'(eb));
        end
        chk("stall", 32'(stall), 32'(es));
        chk("iss_ready", 32'(iss_ready), 32'(m_cnt[iss_addr] < 3));
        chk("err", 32'(err), 32'(m_err));
    endtask

    // clock edge: apply the same inputs to the model
    task automatic tick();
        bit acc;
        bit dec;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            acc = iss_en && m_cnt[iss_addr] < 3;
            dec = wr_en && m_cnt[wr_addr] > 0;
            if (wr_en && m_cnt[wr_addr] == 0) m_err = 1;
            if (wr_en) m_reg[wr_addr] = wr_data;
            if (acc) m_cnt[iss_addr]++;
            if (dec) m_cnt[wr_addr]--;
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; rd_valid = 0; iss_en = 0; wr_en = 0;
        iss_addr = 0; wr_addr = 0; wr_data = 0;
    endtask

    initial begin
        idle();
        rd_addr = 0;
        rst = 1;
        tick();
        model_reset();
        // reset values
        idle(); rd_addr = {3'd5, 3'd0};
        settle();
        chk("reset_ba", 32'(rd_data[15:0]), 32'h0040);
        chk("reset_r5", 32'(rd_data[31:16]), 32'h0000);
        tick();
        // bypass
        wr_en = 1; wr_addr = 4; wr_data = 16'hBEEF; rd_addr = {3'd0, 3'd4};
        settle();
        chk("bypass_now", 32'(rd_data[15:0]), 32'hBEEF);
        tick();
        idle();
        settle();
        chk("bypass_next", 32'(rd_data[15:0]), 32'hBEEF);
        tick();
        // stall and release
        iss_en = 1; iss_addr = 6;
        settle(); tick();
        idle(); rd_valid = 2'b10; rd_addr = {3'd6, 3'd0};
        settle();
        chk("stall_on", 32'(stall), 32'd1);
        tick();
        wr_en = 1; wr_addr = 6; wr_data = 16'h1234;
        settle();
        chk("stall_off", 32'(stall), 32'd0);
        chk("stall_data", 32'(rd_data[31:16]), 32'h1234);
        tick();
        // saturation
        idle(); iss_en = 1; iss_addr = 3; rd_addr = {3'd0, 3'd3};
        for (int n = 0; n < 4; n++) begin
            settle(); tick();
        end
        chk("sat_ready", 32'(iss_ready), 32'd0);
        idle(); rd_addr = {3'd0, 3'd3}; wr_en = 1; wr_addr = 3;
        for (int n = 0; n < 3; n++) begin
            wr_data = 16'(n + 1);
            settle();
            chk($sformatf("sat_busy%0d", n), 32'(rd_busy[0]), 32'(n < 2));
            tick();
        end
        // simultaneous issue and writeback
        idle(); iss_en = 1; iss_addr = 2;
        settle(); tick();
        wr_en = 1; wr_addr = 2; wr_data = 16'h5555;
        settle(); tick();
        idle(); rd_addr = {3'd0, 3'd2};
        settle();
        chk("simul_busy", 32'(rd_busy[0]), 32'd1);
        chk("simul_data", 32'(rd_data[15:0]), 32'h5555);
        tick();
        // error on unclaimed writeback
        wr_en = 1; wr_addr = 7; wr_data = 16'hAAAA;
        settle(); tick();
        idle();
        settle();
        chk("err_set", 32'(err), 32'd1);
        tick();
        // reset mid-operation
        iss_en = 1; iss_addr = 1; wr_en = 1; wr_addr = 1; wr_data = 16'h7777;
        settle(); tick();
        idle(); rst = 1;
        settle(); tick();
        idle(); rd_addr = {3'd0, 3'd1};
        settle();
        chk("rst_busy", 32'(rd_busy[0]), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_data", 32'(rd_data[15:0]), 32'd0);
        tick();
        // random traffic
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 49) == 0);
            rd_valid = 2'($urandom);
            rd_addr  = 6'($urandom);
            iss_en   = 1'($urandom);
            iss_addr = 3'($urandom_range(0, 3));
            wr_en    = 1'($urandom);
            wr_addr  = 3'($urandom_range(0, 3));
            wr_data  = 16'($urandom);
            settle(); tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
